// File: rtl/priority_event_encoder_pkg.sv
// Shared constants and helpers for the registered priority event encoder.
package prio_enc_pkg;

    localparam int unsigned DEFAULT_N_REQ = 16;
    localparam int unsigned MAX_N_REQ     = 256;

    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n);
    endfunction

    // Returned at maximum width; callers size-cast down to their own N_REQ.
    function automatic logic [MAX_N_REQ-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N_REQ-1:0] one;
        one = MAX_N_REQ'(1);
        return (idx < n) ? (one << idx) : '0;
    endfunction

endpackage

// File: rtl/priority_event_encoder_if.sv
// Valid/ready output channel carrying the issued channel index.
interface priority_event_encoder_if
    import prio_enc_pkg::*;
#(
    parameter int unsigned N_REQ = DEFAULT_N_REQ
);
    localparam int unsigned IDX_W = idx_w(N_REQ);

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;

    modport master (output out_valid, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_idx, output out_ready);

endinterface

// File: rtl/priority_event_encoder_pick.sv
// Combinational circular priority search: highest set bit at or below start, wrapping.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N_REQ,
    parameter int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] sel
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    int unsigned    start_u;

    // Window (start, start+N] in the doubled vector covers start down to start+1 with wrap.
    always_comb begin
        start_u = 32'(start);
        dbl     = {vec, vec};
        mask    = '0;
        for (int unsigned i = 0; i < 2*N; i++) begin
            mask[i] = (i > start_u) && (i <= start_u + N);
        end
        masked = dbl & mask;
        found  = |masked;
        sel    = '0;
        for (int unsigned i = 0; i < 2*N; i++) begin
            if (masked[i]) begin
                sel = (i >= N) ? W'(i - N) : W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_event_encoder.sv
// Edge-capturing priority event encoder with valid/ready index output.
// Optional rotating priority when PRIO_ROUND_ROBIN_EN is defined.
module priority_event_encoder
    import prio_enc_pkg::*;
#(
    parameter int unsigned N_REQ = DEFAULT_N_REQ
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_in,
    input  logic                      clr,
    output logic [N_REQ-1:0]          pending,
    output logic                      overflow,
    priority_event_encoder_if.master  out_if
);

    localparam int unsigned IDX_W = idx_w(N_REQ);

    logic [N_REQ-1:0] req_d_q, req_d_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             overflow_q, overflow_d;

    logic [N_REQ-1:0] edge_vec;
    logic [N_REQ-1:0] load_mask;
    logic             stage_free;
    logic             load;
    logic             pick_found;
    logic [IDX_W-1:0] pick_sel;
    logic [IDX_W-1:0] pick_start;

`ifdef PRIO_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    assign pick_start = (rr_ptr_q == '0) ? IDX_W'(N_REQ - 1) : rr_ptr_q - IDX_W'(1);
    assign rr_ptr_d   = load ? pick_sel : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= IDX_W'(N_REQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign pick_start = IDX_W'(N_REQ - 1);
`endif

    prio_pick #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_pick (
        .vec   (pending_q),
        .start (pick_start),
        .found (pick_found),
        .sel   (pick_sel)
    );

    assign edge_vec   = req_in & ~req_d_q;
    assign stage_free = !out_valid_q || out_if.out_ready;
    assign load       = stage_free && pick_found && !clr;

    always_comb begin
        req_d_d     = req_in;
        load_mask   = load ? N_REQ'(onehot(32'(pick_sel), N_REQ)) : '0;
        pending_d   = (pending_q & ~load_mask) | edge_vec;
        overflow_d  = overflow_q | (|(edge_vec & pending_q));
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (stage_free) begin
            out_valid_d = pick_found;
            out_idx_d   = pick_found ? pick_sel : '0;
        end
        if (clr) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d_q     <= '0;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            req_d_q     <= req_d_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pending          = pending_q;
    assign overflow         = overflow_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_idx   = out_idx_q;

endmodule

// File: doc/priority_event_encoder.md
# priority_event_encoder

Parametrised, registered successor to the team's 16-input combinational priority encoder. Captures rising edges on `N_REQ` request lines into a pending register. Emits the index of the highest-priority pending request through a valid/ready output stage, clearing each request as it is issued. Sits between raw event/interrupt sources and a downstream consumer that services one event at a time.

## Interface
- `N_REQ`, default 16: number of request lines; legal range 2..256.
- `IDX_W`, default `$clog2(N_REQ)`: output index width; localparam, not overridable.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `req_in`  in  N_REQ: request lines; bit i is channel i.
- `clr`  in  1: synchronous flush of pending, output stage and overflow.
- `out_valid`  out  1: `out_idx` holds an issued event.
- `out_ready`  in  1: consumer accepts when `out_valid & out_ready`.
- `out_idx`  out  IDX_W: channel number of the issued event.
- `pending`  out  N_REQ: current pending register, for status readback.
- `overflow`  out  1: sticky; set when an edge arrives on an already-pending channel.

## Operation
- **Edge capture**
  - `req_d` registers `req_in`.
  - `edge = req_in & ~req_d`.
  - A level held high never re-triggers.
- **Pending update**, per cycle: `pending <= (pending & ~load_mask) | edge`.
  - Set wins over clear on the same bit in the same cycle.
- **Overflow**: `overflow` sets if `edge & pending` is non-zero, using pre-update `pending`.
  - The channel currently held in the output stage is not pending, so a new edge on it does not set `overflow`.
- **Output stage load**: the stage is free when `!out_valid | out_ready`.
  - If free and `pending != 0`, load the selected index: `out_valid <= 1`, `out_idx <= sel`, `load_mask = onehot(sel)`.
  - If free and `pending == 0`, `out_valid <= 0`.
- **Output stability**: `out_idx` is stable while `out_valid & !out_ready`.
  - Pending edges wait; no reordering of a presented index.
- **Selection**: fixed priority by default; the highest set index wins.
- **`clr`** (synchronous, highest precedence):
  - `pending <= 0`, `out_valid <= 0`, `overflow <= 0`.
  - Edges in the same cycle are discarded.
  - `req_d` still updates.
- **Idle value**: `out_idx` is 0 whenever `out_valid` is 0.

## Timing
- **Reset values**: `req_d` = 0, `pending` = 0, `out_valid` = 0, `out_idx` = 0, `overflow` = 0, RR pointer = `N_REQ-1`.
  - A line already high at reset release counts as an edge on the first clock.
- **Latency**:
  - An edge sampled at clock k sets `pending[i]` after edge k.
  - `out_valid`/`out_idx` become visible after edge k+1 if the stage is free.
  - Minimum is 2 cycles from request rise to `out_valid`.
- **Throughput**: one index per cycle with `out_ready` held high.
- **Back-pressure**: pending continues to accumulate and `overflow` still tracks.
- **Reset mid-operation**: asynchronous; all state clears immediately and no partial transfer completes.

## Configuration
- **Macro `PRIO_ROUND_ROBIN_EN`**
  - **Defined**: rotating priority.
    - A pointer `rr_ptr` records the last loaded index.
    - The search starts at `rr_ptr-1` descending and wraps from 0 to `N_REQ-1`.
    - `rr_ptr` updates on every load and resets to `N_REQ-1`, so the first search starts at `N_REQ-2`.
    - `clr` does not change `rr_ptr`.
  - **Undefined**: fixed highest-index-wins; no pointer register exists.

## Structure
- **Package `prio_enc_pkg`**:
  - default `N_REQ` constant;
  - function `idx_w(n)` returning `$clog2(n)`;
  - function `onehot(idx, n)`.
- **Sub-module `prio_pick`**: combinational.
  - Inputs: vector, start index.
  - Outputs: `found`, `sel`.
  - Implemented as a doubled-vector mask-and-search so the same block serves fixed mode (start = `N_REQ-1`) and round-robin mode.
- The top level holds `req_d`, `pending`, the output register, `overflow` and `rr_ptr`.

## Test plan
All scenarios use `N_REQ=16`.
1. **Single request**: reset, then pulse `req_in[5]` for 1 cycle with `out_ready=1` → `out_valid` rises 2 cycles after the edge, `out_idx=5` for exactly 1 cycle, then `pending=0`.
2. **Fixed priority**: simultaneous edges on bits 3, 9 and 15, `out_ready=1` → `out_idx` sequence 15, 9, 3 on consecutive cycles, then `out_valid=0`.
3. **Back-pressure and overflow**: `out_ready=0`; edge on 7, then edges on 2 and 2 again → `out_idx` holds 7, `pending=0x0004`, `overflow=1`.
   - Raising `out_ready` then yields 2 next.
4. **Held level and clr**: hold `req_in[4]` high for 10 cycles → exactly one issue of 4.
   - Then assert `clr` in the same cycle as an edge on 1 → `pending=0`, `overflow=0`, no issue of 1.
5. **Round robin** (`PRIO_ROUND_ROBIN_EN` defined): keep bits 3 and 9 re-edging every cycle, `out_ready=1` → issues alternate 9, 3, 9, 3 rather than repeating 9.
6. **Async reset mid-stream**: drop `rst_n` while `out_valid=1` with `pending=0x00F0` → all outputs 0 immediately.
   - On release with `req_in=0`, nothing is issued.
